// File: rtl/coyote_qdma_c2h_pkt_buf_if.sv
// Stream bundle for the C2H packet buffer: Coyote AXIS ingress and QDMA C2H egress.
// The slave modport is the buffer's view; master is the surrounding environment.
interface coyote_qdma_c2h_pkt_buf_if #(
    parameter int unsigned QID_W = 11,
    parameter int unsigned LEN_W = 16
);
    logic [511:0]     s_axis_tdata;
    logic [63:0]      s_axis_tkeep;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;

    logic [511:0]     m_c2h_tdata;
    logic [5:0]       m_c2h_mty;
    logic             m_c2h_zero_byte;
    logic             m_c2h_tlast;
    logic [LEN_W-1:0] m_c2h_ctrl_len;
    logic [QID_W-1:0] m_c2h_ctrl_qid;
    logic             m_c2h_tvalid;
    logic             m_c2h_tready;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_c2h_tdata, m_c2h_mty, m_c2h_zero_byte, m_c2h_tlast,
        input  m_c2h_ctrl_len, m_c2h_ctrl_qid, m_c2h_tvalid,
        output m_c2h_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_c2h_tdata, m_c2h_mty, m_c2h_zero_byte, m_c2h_tlast,
        output m_c2h_ctrl_len, m_c2h_ctrl_qid, m_c2h_tvalid,
        input  m_c2h_tready
    );
endinterface

// File: rtl/coyote_qdma_c2h_pkt_buf.sv
// Store-and-forward buffer from Coyote AXIS to QDMA C2H: whole-packet buffering, tkeep->mty, qid tagging.
// Define C2H_PKT_BUF_STATS_EN to build the egress packet/byte counters; otherwise they read as zero.
module coyote_qdma_c2h_pkt_buf #(
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned PKT_DEPTH     = 8,
    parameter int unsigned MAX_PKT_BEATS = 64,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned QID_W         = 11
) (
    input  logic                     aclk,
    input  logic                     areset,
    coyote_qdma_c2h_pkt_buf_if.slave bus,
    input  logic [QID_W-1:0]         cfg_qid,
    output logic                     err_oversize,
    output logic [31:0]              stat_pkt_cnt,
    output logic [31:0]              stat_byte_cnt
);
    localparam int unsigned DW  = 512;
    localparam int unsigned KW  = 64;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PAW = $clog2(PKT_DEPTH);
    localparam int unsigned DCW = AW + 1;
    localparam int unsigned LCW = PAW + 1;
    localparam int unsigned BW  = $clog2(MAX_PKT_BEATS + 1);
    localparam int unsigned PCW = 7;
    localparam logic [BW-1:0] MAX_B = BW'(MAX_PKT_BEATS);

    if (MAX_PKT_BEATS > DEPTH) begin : g_chk_max
        $error("MAX_PKT_BEATS must not exceed DEPTH");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || (PKT_DEPTH & (PKT_DEPTH - 1)) != 0) begin : g_chk_pow2
        $error("DEPTH and PKT_DEPTH must be powers of two");
    end

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [BW-1:0]    beats;
        logic [QID_W-1:0] qid;
        logic             zero;
        logic             trunc;
    } len_ent_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    function automatic logic [PCW-1:0] popcnt(input logic [KW-1:0] k);
        logic [PCW-1:0] s;
        s = '0;
        for (int i = 0; i < KW; i++) s = s + PCW'(k[i]);
        return s;
    endfunction

    // Empty bytes of a final beat; zero-length and truncated packets end on a full beat.
    function automatic logic [5:0] calc_mty(input logic [LEN_W-1:0] len, input logic zero,
                                            input logic trunc);
        if (zero || trunc) return 6'd0;
        return 6'(7'd64 - {1'b0, len[5:0]});
    endfunction

    logic [DW-1:0]    dmem_q [DEPTH];
    len_ent_t         lmem_q [PKT_DEPTH];

    logic [AW-1:0]    dwr_ptr_q, drd_ptr_q;
    logic [PAW-1:0]   lwr_ptr_q, lrd_ptr_q;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [LCW-1:0]   lcnt_q, lcnt_d;
    logic             data_full_q, data_full_d;
    logic             len_full_q, len_full_d;
    logic             len_empty_q, len_empty_d;
    logic             tready_q, tready_d;

    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_acc_q, len_acc_d;
    logic [QID_W-1:0] qid_acc_q, qid_acc_d;
    logic             err_q, err_d;
    logic             data_wr, len_push, discard, in_acc;
    logic [LEN_W-1:0] len_sum;
    len_ent_t         push_ent, head;

    state_e           state_q, state_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic [5:0]       mty_q, mty_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;
    logic [LEN_W-1:0] len_o_q, len_o_d;
    logic [QID_W-1:0] qid_o_q, qid_o_d;
    logic             zero_o_q, zero_o_d;
    logic             trunc_q, trunc_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic [BW-1:0]    ecnt_q, ecnt_d;
    logic             data_rd, eg_done, hs;

    assign head = lmem_q[lrd_ptr_q];

    // Ingress: byte/beat accounting, discard beyond MAX_PKT_BEATS, length-entry build on tlast.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_acc_d  = len_acc_q;
        qid_acc_d  = qid_acc_q;
        err_d      = err_q;
        data_wr    = 1'b0;
        len_push   = 1'b0;
        push_ent   = '0;
        discard    = (beat_cnt_q >= MAX_B);
        in_acc     = bus.s_axis_tvalid && tready_q;
        len_sum    = len_acc_q + (discard ? '0 : LEN_W'(popcnt(bus.s_axis_tkeep)));
        if (in_acc) begin
            data_wr = !discard;
            if (beat_cnt_q == '0) qid_acc_d = cfg_qid;
            if (discard) err_d = 1'b1;
            if (bus.s_axis_tlast) begin
                len_push       = 1'b1;
                push_ent.len   = len_sum;
                push_ent.beats = discard ? beat_cnt_q : beat_cnt_q + BW'(1);
                push_ent.qid   = (beat_cnt_q == '0) ? cfg_qid : qid_acc_q;
                push_ent.zero  = (len_sum == '0);
                push_ent.trunc = discard;
                beat_cnt_d     = '0;
                len_acc_d      = '0;
            end else begin
                len_acc_d = len_sum;
                if (!discard) beat_cnt_d = beat_cnt_q + BW'(1);
            end
        end
    end

    // Egress FSM: wait for a complete packet, latch its control fields, then stream its beats.
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        mty_d    = mty_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        len_o_d  = len_o_q;
        qid_o_d  = qid_o_q;
        zero_o_d = zero_o_q;
        trunc_d  = trunc_q;
        beats_d  = beats_q;
        ecnt_d   = ecnt_q;
        data_rd  = 1'b0;
        eg_done  = 1'b0;
        hs       = tvalid_q && bus.m_c2h_tready;
        case (state_q)
            IDLE: if (!len_empty_q) state_d = LOAD;
            LOAD: begin
                len_o_d  = head.len;
                qid_o_d  = head.qid;
                zero_o_d = head.zero;
                trunc_d  = head.trunc;
                beats_d  = head.beats;
                ecnt_d   = '0;
                tdata_d  = dmem_q[drd_ptr_q];
                data_rd  = 1'b1;
                tlast_d  = (head.beats == BW'(1));
                mty_d    = tlast_d ? calc_mty(head.len, head.zero, head.trunc) : 6'd0;
                tvalid_d = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (tlast_q) begin
                        eg_done  = 1'b1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        mty_d    = 6'd0;
                        state_d  = IDLE;
                    end else begin
                        ecnt_d  = ecnt_q + BW'(1);
                        tdata_d = dmem_q[drd_ptr_q];
                        data_rd = 1'b1;
                        tlast_d = (ecnt_d == beats_q - BW'(1));
                        mty_d   = tlast_d ? calc_mty(len_o_q, zero_o_q, trunc_q) : 6'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy and registered flags; space freed by a pop shows up on the following cycle.
    always_comb begin
        dcnt_d      = dcnt_q + DCW'(data_wr) - DCW'(data_rd);
        lcnt_d      = lcnt_q + LCW'(len_push) - LCW'(eg_done);
        data_full_d = (dcnt_d == DCW'(DEPTH));
        len_full_d  = (lcnt_d == LCW'(PKT_DEPTH));
        len_empty_d = (lcnt_d == '0);
        tready_d    = !len_full_d && (!data_full_d || (beat_cnt_d >= MAX_B));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            dwr_ptr_q   <= '0;
            drd_ptr_q   <= '0;
            lwr_ptr_q   <= '0;
            lrd_ptr_q   <= '0;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            data_full_q <= 1'b0;
            len_full_q  <= 1'b0;
            len_empty_q <= 1'b1;
            tready_q    <= 1'b0;
            beat_cnt_q  <= '0;
            len_acc_q   <= '0;
            qid_acc_q   <= '0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
            tdata_q     <= '0;
            mty_q       <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            len_o_q     <= '0;
            qid_o_q     <= '0;
            zero_o_q    <= 1'b0;
            trunc_q     <= 1'b0;
            beats_q     <= '0;
            ecnt_q      <= '0;
        end else begin
            if (data_wr) dwr_ptr_q <= dwr_ptr_q + AW'(1);
            if (data_rd) drd_ptr_q <= drd_ptr_q + AW'(1);
            if (len_push) lwr_ptr_q <= lwr_ptr_q + PAW'(1);
            if (eg_done) lrd_ptr_q <= lrd_ptr_q + PAW'(1);
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            data_full_q <= data_full_d;
            len_full_q  <= len_full_d;
            len_empty_q <= len_empty_d;
            tready_q    <= tready_d;
            beat_cnt_q  <= beat_cnt_d;
            len_acc_q   <= len_acc_d;
            qid_acc_q   <= qid_acc_d;
            err_q       <= err_d;
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            mty_q       <= mty_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            len_o_q     <= len_o_d;
            qid_o_q     <= qid_o_d;
            zero_o_q    <= zero_o_d;
            trunc_q     <= trunc_d;
            beats_q     <= beats_d;
            ecnt_q      <= ecnt_d;
        end
    end

    // Storage arrays carry no reset; the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (data_wr && !areset) dmem_q[dwr_ptr_q] <= bus.s_axis_tdata;
        if (len_push && !areset) lmem_q[lwr_ptr_q] <= push_ent;
    end

`ifdef C2H_PKT_BUF_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (eg_done) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            byte_cnt_d = byte_cnt_q + 32'(len_o_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_byte_cnt = byte_cnt_q;
`else
    assign stat_pkt_cnt  = 32'd0;
    assign stat_byte_cnt = 32'd0;
`endif

    assign bus.s_axis_tready   = tready_q;
    assign bus.m_c2h_tdata     = tdata_q;
    assign bus.m_c2h_mty       = mty_q;
    assign bus.m_c2h_zero_byte = zero_o_q;
    assign bus.m_c2h_tlast     = tlast_q;
    assign bus.m_c2h_ctrl_len  = len_o_q;
    assign bus.m_c2h_ctrl_qid  = qid_o_q;
    assign bus.m_c2h_tvalid    = tvalid_q;
    assign err_oversize        = err_q;
endmodule
